lcd_responder: RTL and testbench

LCD_RESPONDER -- requirements
Module: lcd_responder

---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_ddram.sv | 35 +++
 rtl/lcd_responder.sv | 179 +++++++++++++++++
 tb/tb_lcd_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder: opcode masks,
// FSM states, DDRAM geometry and address-counter helpers.
package lcd_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, FILL} state_t;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_ENTRY    = 8'h04;
  localparam logic [7:0] OP_DISPLAY  = 8'h08;
  localparam logic [7:0] OP_SHIFT    = 8'h10;
  localparam logic [7:0] OP_FUNCTION = 8'h20;
  localparam logic [7:0] OP_CGRAM    = 8'h40;
  localparam logic [7:0] OP_DDRAM    = 8'h80;

  localparam int         DDRAM_DEPTH = 80;
  localparam int         LINE_LEN    = 40;
  localparam logic [6:0] LINE0_BASE  = 7'h00;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam logic [6:0] LINE0_LAST  = LINE0_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE1_LAST  = LINE1_BASE + 7'(LINE_LEN - 1);
  localparam logic [7:0] SPACE_CODE  = 8'h20;

  // Line 0 starts at address zero, so only its upper bound needs testing.
  function automatic logic ac_valid(input logic [6:0] ac);
    return (ac <= LINE0_LAST) || ((ac >= LINE1_BASE) && (ac <= LINE1_LAST));
  endfunction

  function automatic logic [6:0] ac_index(input logic [6:0] ac);
    return (ac <= LINE0_LAST) ? (ac - LINE0_BASE)
                              : (ac - LINE1_BASE + 7'(LINE_LEN));
  endfunction

  // Stepping jumps across the gap between the two lines in both directions.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == LINE0_LAST)      nxt = LINE1_BASE;
      else if (ac == LINE1_LAST) nxt = LINE0_BASE;
      else                       nxt = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)      nxt = LINE0_LAST;
      else if (ac == LINE0_BASE) nxt = LINE1_LAST;
      else                       nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one write port and two registered read ports,
// one for host bus reads and one for the renderer.
import lcd_pkg::*;

module lcd_ddram (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] bus_addr,
  output logic [7:0] bus_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [DDRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < 7'(DDRAM_DEPTH)))
      mem[waddr] <= wdata;
  end

  // Out-of-range addresses read as a blank so callers can pass a sentinel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_data <= 8'h00;
      rd_data  <= 8'h00;
    end else begin
      bus_data <= (bus_addr < 7'(DDRAM_DEPTH)) ? mem[bus_addr] : SPACE_CODE;
      rd_data  <= (rd_addr  < 7'(DDRAM_DEPTH)) ? mem[rd_addr]  : SPACE_CODE;
    end
  end

endmodule

// File: rtl/lcd_responder.sv
// Responder side of a character-LCD parallel bus: decodes host transfers on
// the falling edge of E, keeps DDRAM and the address counter, models busy time.
import lcd_pkg::*;

module lcd_responder #(
  parameter int BUSY_SHORT = 1850,
  parameter int BUSY_LONG  = 76000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RS,
  input  logic       RW,
  input  logic       E,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic       busy,
  output logic [2:0] disp_ctrl,
  output logic [6:0] cursor_addr,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       drop_err
);

  localparam int CNT_W = $clog2((BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT);
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(BUSY_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(BUSY_LONG - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [6:0]       ac, ac_n, fill_idx, fill_n;
  logic             id, id_n, cg, cg_n, drop, drop_n;
  logic [2:0]       disp, disp_n;

  logic       e_q, rs_q, rw_q, oe_q;
  logic [7:0] d_q, status_q;
  logic       fall;

  logic       we;
  logic [6:0] waddr, bus_addr;
  logic [7:0] wdata, bus_data;

  assign fall        = e_q & ~E;
  assign busy        = (state != IDLE);
  assign cursor_addr = ac;
  assign disp_ctrl   = disp;
  assign drop_err    = drop;
  assign D_oe        = oe_q;
  assign D_out       = oe_q ? (rs_q ? bus_data : status_q) : 8'h00;
  assign bus_addr    = ac_valid(ac) ? ac_index(ac) : 7'h7F;

  // Bus values are held one cycle so the falling-E cycle sees what the host
  // drove while E was still high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      d_q      <= 8'h00;
      oe_q     <= 1'b0;
      status_q <= 8'h00;
    end else begin
      e_q      <= E;
      rs_q     <= RS;
      rw_q     <= RW;
      d_q      <= D_in;
      oe_q     <= E & RW;
      status_q <= {busy, ac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= LONG_LOAD;
      fill_idx <= 7'd0;
      ac       <= 7'd0;
      id       <= 1'b1;
      cg       <= 1'b0;
      disp     <= 3'b000;
      drop     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      fill_idx <= fill_n;
      ac       <= ac_n;
      id       <= id_n;
      cg       <= cg_n;
      disp     <= disp_n;
      drop     <= drop_n;
    end
  end

  // The busy counter runs through FILL and EXEC alike, so a clear lasts
  // BUSY_LONG in total regardless of how long the blanking pass takes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fill_n  = fill_idx;
    ac_n    = ac;
    id_n    = id;
    cg_n    = cg;
    disp_n  = disp;
    drop_n  = drop;
    we      = 1'b0;
    waddr   = fill_idx;
    wdata   = SPACE_CODE;

    case (state)
      FILL: begin
        we    = 1'b1;
        cnt_n = cnt - 1'b1;
        if (fill_idx == 7'(DDRAM_DEPTH - 1)) state_n = EXEC;
        else                                 fill_n  = fill_idx + 7'd1;
      end
      EXEC: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: ;
    endcase

    if (fall) begin
      if (!rw_q && busy) begin
        drop_n = 1'b1;
      end else if (!busy && (rs_q || !rw_q)) begin
        if (rs_q) begin
          if (!rw_q && !cg && ac_valid(ac)) begin
            we    = 1'b1;
            waddr = ac_index(ac);
            wdata = d_q;
          end
          ac_n    = ac_step(ac, id);
          state_n = EXEC;
          cnt_n   = SHORT_LOAD;
        end else if (d_q != 8'h00) begin
          state_n = EXEC;
          cnt_n   = SHORT_LOAD;
          if (|(d_q & OP_DDRAM)) begin
            ac_n = d_q[6:0];
            cg_n = 1'b0;
          end else if (|(d_q & OP_CGRAM)) begin
            cg_n = 1'b1;
          end else if (|(d_q & OP_FUNCTION)) begin
            state_n = EXEC;
          end else if (|(d_q & OP_SHIFT)) begin
            if (!d_q[3]) ac_n = ac_step(ac, d_q[2]);
          end else if (|(d_q & OP_DISPLAY)) begin
            disp_n = d_q[2:0];
          end else if (|(d_q & OP_ENTRY)) begin
            id_n = d_q[1];
          end else if (|(d_q & OP_HOME)) begin
            ac_n  = 7'd0;
            cnt_n = LONG_LOAD;
          end else if (|(d_q & OP_CLEAR)) begin
            state_n = FILL;
            fill_n  = 7'd0;
            cnt_n   = LONG_LOAD;
            ac_n    = 7'd0;
            id_n    = 1'b1;
          end
        end
      end
    end
  end

  lcd_ddram u_ddram (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .bus_addr (bus_addr),
    .bus_data (bus_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_lcd_responder.sv
// Scoreboard bench for lcd_responder: bus and renderer reads are predicted by
// a behavioural display model and checked by an independent monitor.
module tb_lcd_responder;

  // Shortened busy times keep the run small; the relationships are unchanged.
  localparam int BUSY_SHORT = 30;
  localparam int BUSY_LONG  = 300;

  logic       clk = 1'b0;
  logic       rst, RS, RW, E;
  logic [7:0] D_in, D_out, rd_data;
  logic       D_oe, busy, drop_err;
  logic [2:0] disp_ctrl;
  logic [6:0] cursor_addr, rd_addr;

  lcd_responder #(.BUSY_SHORT(BUSY_SHORT), .BUSY_LONG(BUSY_LONG)) dut (
    .clk(clk), .rst(rst), .RS(RS), .RW(RW), .E(E), .D_in(D_in),
    .D_out(D_out), .D_oe(D_oe), .busy(busy), .disp_ctrl(disp_ctrl),
    .cursor_addr(cursor_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Display model: flat 80-cell screen, two 40-cell lines in a ring.
  logic [7:0] m_mem [80];
  logic [6:0] m_ac;
  logic       m_id, m_cg, m_drop;
  logic [2:0] m_disp;
  int         busy_end;

  typedef struct { logic [7:0] val; string name; int due; } exp_t;
  exp_t exp_bus[$];
  exp_t exp_rd[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic bit m_valid(input logic [6:0] a);
    return (a < 7'd40) || (a >= 7'h40 && a < 7'h68);
  endfunction

  function automatic int m_index(input logic [6:0] a);
    return (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
  endfunction

  function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
    int p;
    if (!m_valid(a)) return up ? 7'(a + 7'd1) : 7'(a - 7'd1);
    p = m_index(a);
    p = up ? (p + 1) % 80 : (p + 79) % 80;
    return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
  endfunction

  task automatic modelWrite(input bit rs, input logic [7:0] d, input int f);
    int op = -1;
    if (f - 1 < busy_end) begin
      m_drop = 1'b1;
      return;
    end
    if (rs) begin
      if (!m_cg && m_valid(m_ac)) m_mem[m_index(m_ac)] = d;
      m_ac = m_step(m_ac, m_id);
      busy_end = f + BUSY_SHORT;
      return;
    end
    for (int b = 0; b < 8; b++) if (d[b]) op = b;
    if (op < 0) return;
    busy_end = f + BUSY_SHORT;
    case (op)
      0: begin
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        m_ac = 7'd0; m_id = 1'b1; busy_end = f + BUSY_LONG;
      end
      1: begin m_ac = 7'd0; busy_end = f + BUSY_LONG; end
      2: m_id = d[1];
      3: m_disp = d[2:0];
      4: if (!d[3]) m_ac = m_step(m_ac, d[2]);
      6: m_cg = 1'b1;
      7: begin m_ac = d[6:0]; m_cg = 1'b0; end
      default: ;
    endcase
  endtask

  // All stimulus tasks start and finish on a falling clock edge.
  task automatic applyStimulus_write(input bit rs, input logic [7:0] d);
    int f;
    RS = rs; RW = 1'b0; D_in = d; E = 1'b1;
    repeat (2) @(negedge clk);
    E = 1'b0;
    f = cyc + 1;
    modelWrite(rs, d, f);
    @(negedge clk);
  endtask

  task automatic applyStimulus_read(input bit rs);
    exp_t e;
    int f;
    if (rs) begin
      e.val  = m_valid(m_ac) ? m_mem[m_index(m_ac)] : 8'h20;
      e.name = "data read";
    end else begin
      e.val  = {(cyc < busy_end), m_ac};
      e.name = "status read";
    end
    e.due = 0;
    exp_bus.push_back(e);
    RS = rs; RW = 1'b1; E = 1'b1;
    repeat (2) @(negedge clk);
    E = 1'b0;
    f = cyc + 1;
    if (rs && !(f - 1 < busy_end)) begin
      m_ac = m_step(m_ac, m_id);
      busy_end = f + BUSY_SHORT;
    end
    @(negedge clk);
    RW = 1'b0;
  endtask

  task automatic applyStimulus_render(input int idx);
    exp_t e;
    rd_addr = 7'(idx);
    e.val = m_mem[idx]; e.name = "render read"; e.due = cyc + 1;
    exp_rd.push_back(e);
    @(negedge clk);
  endtask

  task automatic countBusy(input string name, input int expected);
    int n = 0;
    while (busy === 1'b1 && n < expected + 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, n, expected);
  endtask

  task automatic waitIdle();
    int n = 0;
    bit was_busy;
    was_busy = busy;
    while (busy === 1'b1 && n < BUSY_LONG + 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0)  checkOutput("idle timeout", busy, 0);
    else if (was_busy)  checkOutput("busy release cycle", cyc, busy_end);
    else                checkOutput("idle vs model", (cyc >= busy_end), 1);
  endtask

  task automatic checkState();
    checkOutput("cursor_addr", cursor_addr, m_ac);
    checkOutput("disp_ctrl", disp_ctrl, m_disp);
    checkOutput("drop_err", drop_err, m_drop);
  endtask

  // Monitor: a bus read is checked when D_oe rises, a renderer read one
  // cycle after its address was presented.
  initial begin : monitor
    logic prev_oe;
    exp_t e;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (D_oe === 1'b1 && prev_oe !== 1'b1) begin
        if (exp_bus.size() == 0) checkOutput("unexpected D_oe", D_oe, 0);
        else begin
          e = exp_bus.pop_front();
          checkOutput(e.name, D_out, e.val);
        end
      end
      prev_oe = D_oe;
      while (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
        e = exp_rd.pop_front();
        checkOutput(e.name, rd_data, e.val);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] d;
    int kind, b;
    rst = 1'b1; RS = 1'b0; RW = 1'b0; E = 1'b0; D_in = 8'h00; rd_addr = 7'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 1);
    checkOutput("reset D_oe", D_oe, 0);
    checkOutput("reset D_out", D_out, 0);
    checkOutput("reset drop_err", drop_err, 0);
    checkOutput("reset disp_ctrl", disp_ctrl, 0);
    checkOutput("reset cursor_addr", cursor_addr, 0);
    checkOutput("reset rd_data", rd_data, 0);

    for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    m_ac = 7'd0; m_id = 1'b1; m_cg = 1'b0; m_disp = 3'b000; m_drop = 1'b0;
    rst = 1'b0;
    busy_end = cyc + BUSY_LONG;
    countBusy("power-on busy length", BUSY_LONG);
    for (int i = 0; i < 80; i++) applyStimulus_render(i);

    applyStimulus_write(1'b0, 8'h80); waitIdle();
    applyStimulus_write(1'b1, 8'h41); waitIdle();
    applyStimulus_render(0);
    checkOutput("AC after first write", cursor_addr, 7'h01);

    applyStimulus_write(1'b0, 8'hA7); waitIdle();
    applyStimulus_write(1'b1, 8'h5A); waitIdle();
    applyStimulus_render(39);
    checkOutput("AC wrap to line 1", cursor_addr, 7'h40);

    applyStimulus_write(1'b0, 8'h04); waitIdle();
    applyStimulus_write(1'b0, 8'h80); waitIdle();
    applyStimulus_write(1'b1, 8'h66); waitIdle();
    checkOutput("AC decrement wrap", cursor_addr, 7'h67);
    applyStimulus_write(1'b0, 8'h06); waitIdle();

    applyStimulus_write(1'b0, 8'h80); waitIdle();
    applyStimulus_write(1'b1, 8'h33);
    applyStimulus_write(1'b1, 8'h77);
    applyStimulus_read(1'b0);
    waitIdle();
    applyStimulus_render(0);
    applyStimulus_render(1);
    checkOutput("drop_err sticky", drop_err, 1);

    applyStimulus_write(1'b0, 8'h0F);
    countBusy("display control busy length", BUSY_SHORT);
    checkOutput("disp_ctrl all on", disp_ctrl, 3'b111);
    waitIdle();
    checkState();

    for (int n = 0; n < 40; n++) begin
      waitIdle();
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        applyStimulus_write(1'b1, 8'($urandom));
      end else if (kind <= 6) begin
        b = $urandom_range(0, 8);
        if (b == 8) d = 8'h00;
        else begin
          d = 8'($urandom);
          d = (d & 8'((1 << b) - 1)) | 8'(1 << b);
        end
        applyStimulus_write(1'b0, d);
      end else if (kind == 7) begin
        applyStimulus_read(1'b1);
      end else if (kind == 8) begin
        applyStimulus_read(1'b0);
      end else begin
        repeat (3) applyStimulus_render($urandom_range(0, 79));
      end
      checkState();
    end

    waitIdle();
    for (int i = 0; i < 80; i++) applyStimulus_render(i);
    repeat (4) @(negedge clk);
    checkOutput("scoreboard drained", exp_bus.size() + exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
